// File: rtl/meter_pkg.sv
// Shared constants for the parking-meter key scheduler: key map, FSM encoding
// and the fixed grant priority.
package meter_pkg;

    localparam int NUM_KEYS = 6;

    localparam int KEY_ADD1 = 0;
    localparam int KEY_ADD2 = 1;
    localparam int KEY_ADD3 = 2;
    localparam int KEY_ADD4 = 3;
    localparam int KEY_RST1 = 4;
    localparam int KEY_RST2 = 5;

    // Keys that count as a paid command
    localparam logic [NUM_KEYS-1:0] ADD_MASK = 6'b001111;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t GAP   = 2'd2;

    // Highest priority first
    localparam int PRIO_ORDER [NUM_KEYS] = '{KEY_RST1, KEY_RST2, KEY_ADD4,
                                             KEY_ADD3, KEY_ADD2, KEY_ADD1};

    // Walk from lowest to highest priority so the last hit is the winner
    function automatic logic [NUM_KEYS-1:0] pick_grant(input logic [NUM_KEYS-1:0] req);
        logic [NUM_KEYS-1:0] g;
        g = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            g = req[PRIO_ORDER[i]] ? (NUM_KEYS'(1) << PRIO_ORDER[i]) : g;
        end
        return g;
    endfunction

endpackage

// File: rtl/meter_key_scheduler_debounce.sv
// Single-key conditioner: two-flop synchroniser followed by a mismatch-count
// debouncer that only accepts a level held for DB_CYCLES cycles.
module key_debounce #(
    parameter int DB_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic db
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;
    logic          db_r;

    // Synchroniser chain for the asynchronous button line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counter and accepted level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
            db_r  <= 1'b0;
        end else if (sync2_r == db_r) begin
            cnt_r <= '0;
            db_r  <= db_r;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            db_r  <= sync2_r;
        end else begin
            cnt_r <= cnt_r + 1'b1;
            db_r  <= db_r;
        end
    end

    assign db = db_r;

endmodule

// File: rtl/meter_key_scheduler.sv
// Front-panel key scheduler: debounced presses are latched as pending and
// issued one at a time as one-hot pulses with a fixed hold-off between them.
module meter_key_scheduler
    import meter_pkg::*;
#(
    parameter int DB_CYCLES  = 3,
    parameter int GAP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_KEYS-1:0] btn_raw,
    output logic [NUM_KEYS-1:0] cmd,
    output logic [NUM_KEYS-1:0] pend,
    output logic                busy,
    output logic                drop,
    output logic [7:0]          paid_cnt
);

    localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    logic [NUM_KEYS-1:0] db_s;
    logic [NUM_KEYS-1:0] db_q_r;
    logic [NUM_KEYS-1:0] rise_s;
    logic [NUM_KEYS-1:0] pend_r;
    logic [NUM_KEYS-1:0] pend_next_s;
    logic [NUM_KEYS-1:0] grant_s;
    logic [NUM_KEYS-1:0] cmd_r;
    state_t              state_r;
    state_t              state_next_s;
    logic [GW-1:0]       gap_cnt_r;
    logic                busy_r;
    logic                drop_r;
    logic                drop_next_s;
    logic [7:0]          paid_r;
    logic                paid_inc_s;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[k]),
            .db      (db_s[k])
        );
    end

    assign rise_s = db_s & ~db_q_r;

    // Arbitration, next state and pending bookkeeping
    always_comb begin
        grant_s      = '0;
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (en && (pend_r != '0)) begin
                    grant_s      = pick_grant(pend_r);
                    state_next_s = ISSUE;
                end else begin
                    grant_s      = '0;
                    state_next_s = IDLE;
                end
            end
            ISSUE:   state_next_s = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     state_next_s = (gap_cnt_r == '0) ? IDLE : GAP;
            default: state_next_s = IDLE;
        endcase
        // A fresh rise on the key being granted re-arms it rather than being lost
        pend_next_s = (pend_r & ~grant_s) | rise_s;
        drop_next_s = |(rise_s & pend_r & ~grant_s);
        paid_inc_s  = (|(grant_s & ADD_MASK)) && (paid_r != 8'd255);
    end

    // Edge history, pending flags and drop pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q_r <= '0;
            pend_r <= '0;
            drop_r <= 1'b0;
        end else begin
            db_q_r <= db_s;
            pend_r <= pend_next_s;
            drop_r <= drop_next_s;
        end
    end

    // FSM, hold-off counter and registered command outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            gap_cnt_r <= '0;
            cmd_r     <= '0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cmd_r   <= grant_s;
            busy_r  <= (state_next_s != IDLE);
            if (state_r == ISSUE) begin
                gap_cnt_r <= GW'(GAP_LOAD);
            end else if ((state_r == GAP) && (gap_cnt_r != '0)) begin
                gap_cnt_r <= gap_cnt_r - 1'b1;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
        end
    end

    // Saturating count of paid commands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            paid_r <= 8'd0;
        end else if (paid_inc_s) begin
            paid_r <= paid_r + 8'd1;
        end else begin
            paid_r <= paid_r;
        end
    end

    assign cmd      = cmd_r;
    assign pend     = pend_r;
    assign busy     = busy_r;
    assign drop     = drop_r;
    assign paid_cnt = paid_r;

endmodule

// File: doc/meter_key_scheduler.md
# meter_key_scheduler

Input-side controller for the parking meter. It conditions the six raw front-panel key lines (add1–add4, rst1, rst2) with synchronisation, debounce and rising-edge detection. Detected presses are queued in per-key pending flags and issued to the meter datapath as single-cycle, one-hot command pulses, granted by fixed priority and spaced by a programmable hold-off. The block sits between the board buttons and the meter's key inputs, so the meter never sees bounce, simultaneous keys or held keys.

## Interface
- DB_CYCLES, 3, consecutive cycles a synchronised level must differ from the debounced level before it is accepted (≥1)
- GAP_CYCLES, 4, idle cycles inserted after every issued command (≥0)
- clk  input  1  system clock (100 Hz meter clock)
- rst  input  1  asynchronous, active-low reset
- en  input  1  grant enable; low blocks new grants, presses are still collected
- btn_raw  input  6  raw keys; bit map add1=0, add2=1, add3=2, add4=3, rst1=4, rst2=5
- cmd  output  6  one-hot command pulse, same bit map; drives the meter key inputs
- pend  output  6  pending flags, registered
- busy  output  1  high when state ≠ IDLE
- drop  output  1  one-cycle pulse when a press hits a key already pending
- paid_cnt  output  8  saturating count of issued add1–add4 commands

## Operation
- Reset values: cmd=0, pend=0, busy=0, drop=0, paid_cnt=0, state=IDLE, sync/debounce registers=0, counters=0.
- Sync: 2-flop synchroniser per bit.
- Debounce, per bit:
  - If the sync level equals db, the counter clears.
  - Otherwise the counter increments. When it reaches DB_CYCLES−1 while still mismatched, db takes the sync level and the counter clears.
- Edge: rise[i] = db[i] & ~db_q[i].
- Pending:
  - rise[i] sets pend[i].
  - A grant of key i clears pend[i].
  - If rise[i] and a grant of i happen in the same cycle, the set wins.
  - rise[i] while pend[i]=1 and i is not being granted pulses drop; pend is unchanged.
- Arbitration: fixed priority rst1 > rst2 > add4 > add3 > add2 > add1.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if en=1 and pend≠0, then grant g = highest-priority pending key, cmd←onehot(g), pend[g]←0, state←ISSUE. If g is add1–add4 and paid_cnt<255, paid_cnt increments.
  - ISSUE: cmd←0. If GAP_CYCLES=0, state←IDLE. Otherwise gap_cnt←GAP_CYCLES−1 and state←GAP.
  - GAP: if gap_cnt=0, state←IDLE; otherwise gap_cnt decrements.
- Widths:
  - debounce counter: clog2(DB_CYCLES+1)
  - gap_cnt: clog2(GAP_CYCLES+1), minimum 1
  - paid_cnt saturates at 255 and never wraps.
- en deasserted during ISSUE or GAP does not cut short a pulse or the gap. It only blocks the next grant.
- A held key produces exactly one rise and one command. Release followed by a new press produces another.

## Timing
- Latency from a btn_raw transition to the db change: 2 + DB_CYCLES clock edges.
- rise is combinational in the cycle db rises.
- pend is set at the next edge.
- cmd is high in the cycle after pend is seen in IDLE, i.e. 2 edges after the db rise when the FSM is idle.
- cmd is high for exactly 1 cycle.
- Minimum spacing between cmd pulses is GAP_CYCLES+2 cycles; with defaults, 6.
- busy is high from the ISSUE cycle through the last GAP cycle.
- Reset assertion clears all outputs immediately, mid-pulse or mid-gap. Operation resumes on the first edge after deassertion.

## Structure
- Package meter_pkg:
  - NUM_KEYS=6
  - key index constants KEY_ADD1…KEY_RST2
  - state typedef {IDLE, ISSUE, GAP}
  - priority order list
- Sub-module key_debounce, single bit: sync + debounce counter + db register. Instantiate 6 times.
- The top level holds the edge detection, pend, the arbiter, the FSM and paid_cnt.

## Test plan
Defaults are DB_CYCLES=3 and GAP_CYCLES=4 unless a scenario says otherwise.
- btn_raw[0] rises and is held → exactly one cmd=6'b000001 pulse, 7 edges after the rise; paid_cnt=1; no further pulses while held.
- btn_raw[2] toggles every cycle for 10 cycles, then stays high → no cmd during the toggling; one cmd=6'b000100 after the level settles.
- add1, add4 and rst1 rise in the same cycle → cmd sequence 6'b010000, 6'b001000, 6'b000001, spaced 6 cycles apart; paid_cnt=2.
- en=0, then add2 is pressed, released and pressed again → pend[1]=1, one drop pulse, no cmd; after en=1, one cmd=6'b000010.
- rst driven low during ISSUE → cmd, pend, busy and paid_cnt all 0 immediately; after release, a fresh press is issued normally.
- 260 add3 presses → paid_cnt stops at 255; with GAP_CYCLES=0, the spacing between grants is 2 cycles.
